// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-requester arbiter with bulk-clear sweep for the word store
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int WordSize  = 32,
  parameter int WordCount = 128,
  parameter int AdrBits   = $clog2(WordCount)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                we0,
  input  logic [AdrBits-1:0]  adr0,
  input  logic [WordSize-1:0] din0,
  input  logic                req1,
  input  logic                we1,
  input  logic [AdrBits-1:0]  adr1,
  input  logic [WordSize-1:0] din1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [WordSize-1:0] rdata,
  input  logic                sweep,
  output logic                busy,
  output logic                sweepDone,
  output logic [AdrBits-1:0]  memAdr,
  output logic [WordSize-1:0] memDataIn,
  output logic                memWrite,
  output logic                memClr,
  input  logic [WordSize-1:0] memDataOut
);

  typedef enum logic {IDLE, SWEEP} stateT;

  // Last address of the store; the sweep stops here so odd sizes never wrap.
  localparam logic [AdrBits-1:0] LastAdr = AdrBits'(WordCount - 1);

  stateT              state;
  logic [AdrBits-1:0] cnt;
  logic               lastGnt;   // 1 = requester 1 won most recently
  logic               idle;

  assign idle  = (state == IDLE);
  assign rdata = memDataOut;

  // Grants: a sweep request pre-empts both requesters; ties go to whoever did not win last.
  always_comb begin
    gnt0 = idle && !sweep && req0 && (!req1 || lastGnt);
    gnt1 = idle && !sweep && req1 && (!req0 || !lastGnt);
    busy = !idle;
  end

  // Memory steering: sweep drives the clear address, otherwise the granted requester or zeros.
  always_comb begin
    memClr    = !idle;
    memWrite  = (gnt0 && we0) || (gnt1 && we1);
    memAdr    = '0;
    memDataIn = '0;
    if (!idle) begin
      memAdr = cnt;
    end else if (gnt0) begin
      memAdr    = adr0;
      memDataIn = din0;
    end else if (gnt1) begin
      memAdr    = adr1;
      memDataIn = din1;
    end
  end

  // Control state, round-robin memory, sweep counter and registered read/sweep strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lastGnt   <= 1'b1;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      sweepDone <= 1'b0;
    end else begin
      rvalid0   <= gnt0 && !we0;
      rvalid1   <= gnt1 && !we1;
      sweepDone <= 1'b0;
      if (gnt0) begin
        lastGnt <= 1'b0;
      end else if (gnt1) begin
        lastGnt <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sweep) begin
            state <= SWEEP;
            cnt   <= '0;
          end
        end
        SWEEP: begin
          if (cnt == LastAdr) begin
            state     <= IDLE;
            sweepDone <= 1'b1;
          end else begin
            cnt <= cnt + AdrBits'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a behavioural model
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int WS = 32;
  localparam int WC = 128;
  localparam int AB = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, sweep = 1'b0;
  logic [AB-1:0] adr0 = '0, adr1 = '0;
  logic [WS-1:0] din0 = '0, din1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, sweepDone, memWrite, memClr;
  logic [WS-1:0] rdata, memDataIn;
  logic [WS-1:0] memDataOut = '0;
  logic [AB-1:0] memAdr;

  mem_arbiter #(.WordSize(WS), .WordCount(WC)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .adr0(adr0), .din0(din0),
    .req1(req1), .we1(we1), .adr1(adr1), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .sweep(sweep), .busy(busy), .sweepDone(sweepDone),
    .memAdr(memAdr), .memDataIn(memDataIn), .memWrite(memWrite), .memClr(memClr),
    .memDataOut(memDataOut)
  );

  always #5 clk = ~clk;

  // Word store attached to the arbiter: clear/write at the edge, registered read of old data.
  logic [WS-1:0] memArr [WC];
  always @(posedge clk) begin
    if (memClr) memArr[memAdr] <= '0;
    else if (memWrite) memArr[memAdr] <= memDataIn;
    memDataOut <= memArr[memAdr];
  end

  int total = 0;
  int bad = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: expected memory image, sweep progress, fairness memory and pending read result.
  logic [WS-1:0] refMem [WC];
  bit            mSweeping = 0;
  int            mNext = 0;
  int            lastWin = 1;
  bit            mRv0 = 0, mRv1 = 0, mDone = 0;
  logic [WS-1:0] mRdata = '0;
  bit            expG0, expG1, expDone;
  bit            obsG0, obsG1, obsBusy, obsDone, obsRv0, obsRv1;
  logic [WS-1:0] obsRdata;

  task automatic modelReset();
    mSweeping = 0; lastWin = 1; mRv0 = 0; mRv1 = 0; mDone = 0;
  endtask

  task automatic stepCycle();
    bit            idle;
    logic [31:0]   eAdr, eDin;
    bit            eWr;
    #1;
    idle  = !mSweeping;
    expG0 = idle && !sweep && req0 && (!req1 || lastWin == 1);
    expG1 = idle && !sweep && req1 && (!req0 || lastWin == 0);
    eAdr  = mSweeping ? mNext : expG0 ? 32'(adr0) : expG1 ? 32'(adr1) : 0;
    eDin  = expG0 ? din0 : expG1 ? din1 : 0;
    eWr   = (expG0 && we0) || (expG1 && we1);
    expDone = mDone;
    checkVal("gnt0", gnt0, expG0);
    checkVal("gnt1", gnt1, expG1);
    checkVal("busy", busy, mSweeping);
    checkVal("memClr", memClr, mSweeping);
    checkVal("memWrite", memWrite, eWr);
    checkVal("memAdr", memAdr, eAdr);
    checkVal("memDataIn", memDataIn, eDin);
    checkVal("rvalid0", rvalid0, mRv0);
    checkVal("rvalid1", rvalid1, mRv1);
    checkVal("sweepDone", sweepDone, mDone);
    if (mRv0 || mRv1) checkVal("rdata", rdata, mRdata);
    obsG0 = gnt0; obsG1 = gnt1; obsBusy = busy; obsDone = sweepDone;
    obsRv0 = rvalid0; obsRv1 = rvalid1; obsRdata = rdata;
    @(posedge clk);
    mRv0 = expG0 && !we0;
    mRv1 = expG1 && !we1;
    if (mRv0) mRdata = refMem[adr0];
    if (mRv1) mRdata = refMem[adr1];
    if (expG0) lastWin = 0;
    if (expG1) lastWin = 1;
    if (expG0 && we0) refMem[adr0] = din0;
    if (expG1 && we1) refMem[adr1] = din1;
    mDone = 0;
    if (mSweeping) begin
      refMem[mNext] = '0;
      if (mNext == WC - 1) begin
        mSweeping = 0;
        mDone = 1;
      end else begin
        mNext++;
      end
    end else if (sweep) begin
      mSweeping = 1;
      mNext = 0;
    end
    @(negedge clk);
  endtask

  task automatic doAccess(input int who, input bit w, input int a, input logic [WS-1:0] d);
    bit got = 0;
    if (who == 0) begin req0 = 1; we0 = w; adr0 = a[AB-1:0]; din0 = d; end
    else          begin req1 = 1; we1 = w; adr1 = a[AB-1:0]; din1 = d; end
    for (int n = 0; n < 300 && !got; n++) begin
      stepCycle();
      got = (who == 0) ? expG0 : expG1;
    end
    checkVal("accessGranted", got, 1);
    if (who == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic doReset();
    rst = 1;
    #1;
    checkVal("rstBusy", busy, 0);
    checkVal("rstMemClr", memClr, 0);
    checkVal("rstRvalid0", rvalid0, 0);
    checkVal("rstRvalid1", rvalid1, 0);
    checkVal("rstSweepDone", sweepDone, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    modelReset();
  endtask

  initial begin
    int nBusy, nDone;
    bit seen;
    @(posedge clk);
    @(negedge clk);
    doReset();
    stepCycle();

    // Fill every word with nonzero data; word 5 carries a known pattern.
    for (int i = 0; i < WC; i++)
      doAccess(i % 2, 1, i, (i == 5) ? 32'hDEADBEEF : ($urandom | 32'h1));

    // Single read of word 5 by requester 0.
    doAccess(0, 0, 5, 0);
    stepCycle();
    checkVal("rd5Rvalid0", obsRv0, 1);
    checkVal("rd5Rvalid1", obsRv1, 0);
    checkVal("rd5Data", obsRdata, 32'hDEADBEEF);

    // Round-robin from reset with both requesters held.
    doReset();
    req0 = 1; we0 = 0; adr0 = 7'd10;
    req1 = 1; we1 = 0; adr1 = 7'd20;
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      checkVal("rrGnt0", obsG0, (k % 2 == 0));
      checkVal("rrGnt1", obsG1, (k % 2 == 1));
    end
    req0 = 0; req1 = 0;
    stepCycle();

    // Requester 1 writes then reads the top word.
    doAccess(1, 1, 127, 32'h12345678);
    doAccess(1, 0, 127, 0);
    stepCycle();
    checkVal("wr127Rvalid1", obsRv1, 1);
    checkVal("wr127Data", obsRdata, 32'h12345678);

    // Sweep raised together with two pending reads.
    req0 = 1; we0 = 0; adr0 = 7'd0;
    req1 = 1; we1 = 0; adr1 = 7'd64;
    sweep = 1;
    stepCycle();
    checkVal("sweepStartGnt0", obsG0, 0);
    checkVal("sweepStartGnt1", obsG1, 0);
    sweep = 0;
    nBusy = 0; nDone = 0;
    for (int n = 0; n < 140 && (req0 || req1); n++) begin
      stepCycle();
      nBusy += int'(obsBusy);
      nDone += int'(obsDone);
      if (expG0) req0 = 0;
      if (expG1) req1 = 0;
    end
    checkVal("sweepBusyCycles", nBusy, 128);
    checkVal("sweepDonePulses", nDone, 1);
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      doAccess(k % 2, 0, (k == 0) ? 0 : (k == 1) ? 64 : 127, 0);
      stepCycle();
      checkVal("clearedWord", obsRdata, 0);
    end

    // Sweep and requester 0 rise together; requester 0 wins in the sweepDone cycle.
    req0 = 1; we0 = 0; adr0 = 7'd3;
    sweep = 1;
    stepCycle();
    checkVal("colStartGnt0", obsG0, 0);
    sweep = 0;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      stepCycle();
      if (expDone) begin
        seen = 1;
        checkVal("colDoneGnt0", obsG0, 1);
      end
    end
    checkVal("colDoneSeen", seen, 1);
    req0 = 0;
    stepCycle();

    // Reset while the sweep is issuing address 40.
    sweep = 1;
    stepCycle();
    sweep = 0;
    repeat (40) stepCycle();
    checkVal("midBusyBefore", obsBusy, 1);
    req0 = 1; we0 = 0; adr0 = 7'd41;
    doReset();
    stepCycle();
    checkVal("postRstGnt0", obsG0, 1);
    req0 = 0;
    nDone = 0;
    for (int n = 0; n < 140; n++) begin
      stepCycle();
      nDone += int'(obsDone);
    end
    checkVal("midNoDone", nDone, 0);

    // Random traffic with occasional sweeps.
    for (int c = 0; c < 1500; c++) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; we0 = 1'($urandom_range(0, 1)); adr0 = 7'($urandom_range(0, 127)); din0 = $urandom;
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; we1 = 1'($urandom_range(0, 1)); adr1 = 7'($urandom_range(0, 127)); din1 = $urandom;
      end
      sweep = ($urandom_range(0, 149) == 0);
      stepCycle();
      if (expG0) req0 = 0;
      if (expG1) req1 = 0;
    end
    sweep = 0; req0 = 0; req1 = 0;
    stepCycle();
    stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port `Memory` word store between two requesters (e.g. the data loader and the regression datapath) with round-robin arbitration. It also provides a controller-driven bulk-clear sweep that zeroes every word through the memory's `clr` input. It sits between the requesters/control unit and the memory. It drives `adr`/`dataIn`/`write`/`clr` and steers the memory's registered `dataOut` back to the requester that issued the read.

## Interface
- `WordSize`, 32, data width; must match the memory.
- `WordCount`, 128, number of words; must match the memory.
- `AdrBits`, ceil(log2(WordCount)), address width (derived).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  requester n has a pending access.
- `we0` / `we1`  in  1  1 = write, 0 = read; qualified by `reqn`.
- `adr0` / `adr1`  in  AdrBits  access address.
- `din0` / `din1`  in  WordSize  write data.
- `gnt0` / `gnt1`  out  1  access accepted this cycle (combinational).
- `rvalid0` / `rvalid1`  out  1  `rdata` holds requester n's read result.
- `rdata`  out  WordSize  pass-through of `memDataOut`.
- `sweep`  in  1  start a bulk clear (single-cycle pulse or level).
- `busy`  out  1  a sweep is in progress.
- `sweepDone`  out  1  one-cycle pulse after the last word is cleared.
- `memAdr`  out  AdrBits  to the memory's `adr`.
- `memDataIn`  out  WordSize  to the memory's `dataIn`.
- `memWrite`  out  1  to the memory's `write`.
- `memClr`  out  1  to the memory's `clr`.
- `memDataOut`  in  WordSize  from the memory's `dataOut` (1-cycle registered read).

## Operation
- **States:** IDLE and SWEEP.
- **IDLE → SWEEP:** when `sweep` = 1. Sweep has priority over requesters, so no grant is issued in that cycle and the counter `cnt` loads 0.
- **SWEEP, each cycle:** `memClr` = 1, `memAdr` = `cnt`, `busy` = 1, `gnt0` = `gnt1` = 0, `cnt` increments.
- **SWEEP → IDLE:** when `cnt` = WordCount-1 (after that address is issued). The counter never wraps past WordCount-1, including for non-power-of-two WordCount.
- **`sweep` while in SWEEP:** ignored; no restart.
- **Arbitration in IDLE:**
  - Only one `reqn` high: that requester is granted.
  - Both high: the requester not in `lastGnt` is granted.
  - `lastGnt` updates on every grant.
- **Granted access:** `memAdr` = `adrn`, `memDataIn` = `dinn`, `memWrite` = `wen`, `memClr` = 0.
- **No grant:** `memWrite` = `memClr` = 0, `memAdr` = 0, `memDataIn` = 0.
- **Requester obligation:** hold `reqn`/`wen`/`adrn`/`dinn` stable until `gntn`. The losing requester simply stays pending.
- **Read return:** a read granted in cycle N sets `rvalidn` = 1 in cycle N+1 only. `rdata` is valid during that cycle. Writes never raise `rvalid`.
- **Back-to-back:** a new grant is allowed every cycle. `rvalid` and a new grant may overlap.

## Timing
- **Reset values:** state IDLE, `cnt` = 0, `lastGnt` = 1 (requester 0 wins the first tie), `rvalid0` = `rvalid1` = 0, `sweepDone` = 0, `busy` = 0.
- **Combinational outputs:** `gnt`, `mem*` and `busy` are combinational from state and inputs. `rvalidn` and `sweepDone` are registered.
- **Read latency:** 1 cycle from grant to `rvalid`.
- **Write/clear:** take effect at the granting cycle's clock edge.
- **Sweep timing:** sweep accepted at edge E. Clears issue in cycles E+1 … E+WordCount. `sweepDone` = 1 in cycle E+WordCount+1, with state already IDLE, so grants are possible in that same cycle.
- **Read granted in the cycle `sweep` rises:** impossible; sweep priority blocks it. A read granted one cycle earlier still returns its `rvalid` during the first SWEEP cycle.
- **`rst` mid-sweep:** immediate return to IDLE with all registers reset, and no `sweepDone`. Memory contents are governed by the memory's own `rst`.

## Test plan
- **Single read:** preload word 5 = 0xDEADBEEF. `req0` = 1, `we0` = 0, `adr0` = 5 → `gnt0` same cycle; next cycle `rvalid0` = 1 and `rdata` = 0xDEADBEEF; `rvalid1` = 0.
- **Round-robin:** `req0` = `req1` = 1 held for 4 cycles after reset → grants alternate 0, 1, 0, 1; `memAdr` follows the granted address.
- **Write then read:** requester 1 writes 0x12345678 to address 127, then reads it → `rvalid1` = 1 with `rdata` = 0x12345678 one cycle after the read grant.
- **Sweep:** fill all words with nonzero data, pulse `sweep` with both requests pending → `busy` = 1 and no grants for exactly 128 cycles; `memClr` = 1 with `memAdr` 0…127; `sweepDone` pulses once; subsequent reads of addresses 0, 64 and 127 return 0.
- **Sweep collision:** `sweep` and `req0` rise in the same cycle → `gnt0` = 0; `req0` is granted in the `sweepDone` cycle.
- **Reset mid-sweep:** assert `rst` at `cnt` = 40 → `busy` = 0 immediately, no `sweepDone`, and `req0` is granted in the first cycle after `rst` falls.
